// File: rtl/bipolar_to_twos_pkg.sv
// -----------------------------------------------------------------------------
// bipolar_to_twos_pkg
//   Shared accelerator definitions for the bipolar-to-two's-complement
//   converter: the pairing FSM state encoding and the phase-plane constants
//   carried on in_phase.
// -----------------------------------------------------------------------------
package bipolar_to_twos_pkg;

    // Pairing FSM: wait for the positive plane, wait for the negative plane,
    // then hold the result until downstream takes it.
    typedef enum logic [1:0] {
        WAIT_P = 2'd0,
        WAIT_N = 2'd1,
        OUT    = 2'd2
    } b2t_state_e;

    // in_phase encoding
    localparam logic PHASE_P = 1'b0;
    localparam logic PHASE_N = 1'b1;

endpackage : bipolar_to_twos_pkg

// File: rtl/bipolar_lane_sub.sv
// -----------------------------------------------------------------------------
// bipolar_lane_sub
//   One lane of the bipolar combine: zero-extends both unsigned magnitudes by
//   one bit and subtracts. With magBits+1 result bits the difference always
//   fits (|p - n| <= 2^magBits - 1), so no saturation is needed.
//
// Ports
//   i_p     in   [magBits-1:0]  positive-plane magnitude
//   i_n     in   [magBits-1:0]  negative-plane magnitude
//   o_twos  out  signed [magBits:0]  p - n in two's complement
// -----------------------------------------------------------------------------
module bipolar_lane_sub #(
    parameter int magBits = 4
) (
    input  logic        [magBits-1:0] i_p,
    input  logic        [magBits-1:0] i_n,
    output logic signed [magBits:0]   o_twos
);

    logic signed [magBits:0] w_p_ext;
    logic signed [magBits:0] w_n_ext;

    assign w_p_ext = $signed({1'b0, i_p});
    assign w_n_ext = $signed({1'b0, i_n});
    assign o_twos  = w_p_ext - w_n_ext;

endmodule : bipolar_lane_sub

// File: rtl/bipolar_to_twos.sv
// -----------------------------------------------------------------------------
// bipolar_to_twos
//   Combines a positive-plane beat (p) and a negative-plane beat (n) of
//   unsigned per-lane magnitudes into a signed two's-complement result
//   p - n per lane. In unsigned mode only the p beat is sent and the result
//   is zext(p). Valid/ready handshakes on both sides; one result register
//   that is reloaded in the same cycle it is consumed, so back-to-back
//   unsigned beats stream at one result per cycle.
//
// Ports
//   clk              in   rising-edge clock
//   nrst             in   asynchronous active-low reset
//   unsigned_inputs  in   1 = p-only pairs (sampled with the p beat)
//   in_valid         in   input beat valid
//   in_ready         out  beat accepted this cycle when in_valid is high
//   in_phase         in   0 = positive plane, 1 = negative plane
//   in_mag           in   [numLanes][magBits] unsigned magnitudes
//   out_valid        out  result valid
//   out_ready        in   downstream takes the result
//   out_twos         out  signed [numLanes][magBits+1] results
//   phase_err        out  one-cycle pulse on an out-of-order phase beat
// -----------------------------------------------------------------------------
module bipolar_to_twos #(
    parameter int magBits  = 4,
    parameter int numLanes = 1
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 unsigned_inputs,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_phase,
    input  logic        [numLanes-1:0][magBits-1:0] in_mag,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [numLanes-1:0][magBits:0]   out_twos,
    output logic                                 phase_err
);

    import bipolar_to_twos_pkg::*;

    b2t_state_e                            r_state;
    b2t_state_e                            w_state_nxt;
    logic        [numLanes-1:0][magBits-1:0] r_p;
    logic        [numLanes-1:0][magBits-1:0] w_p_nxt;
    logic signed [numLanes-1:0][magBits:0]   r_twos;
    logic signed [numLanes-1:0][magBits:0]   w_twos_nxt;
    logic                                  r_perr;
    logic                                  w_perr_nxt;

    logic        [numLanes-1:0][magBits:0]   w_diff;
    logic        [numLanes-1:0][magBits:0]   w_zext;
    logic                                  w_accept;

    // Per-lane combine of the stored p with the incoming n magnitude.
    for (genvar l = 0; l < numLanes; l++) begin : g_lane
        bipolar_lane_sub #(
            .magBits (magBits)
        ) u_sub (
            .i_p    (r_p[l]),
            .i_n    (in_mag[l]),
            .o_twos (w_diff[l])
        );
        assign w_zext[l] = {1'b0, in_mag[l]};
    end

    // While holding a result we can only take a new beat if the held one
    // leaves in the same cycle.
    assign in_ready  = (r_state != OUT) || out_ready;
    assign out_valid = (r_state == OUT);
    assign w_accept  = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath-load logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_twos_nxt  = r_twos;
        w_perr_nxt  = 1'b0;

        unique case (r_state)
            WAIT_P, OUT: begin
                // Held result leaves; a same-cycle p beat below may
                // immediately start the next pair.
                if (r_state == OUT && out_ready) begin
                    w_state_nxt = WAIT_P;
                end
                if (w_accept) begin
                    if (in_phase == PHASE_P) begin
                        w_p_nxt = in_mag;
                        if (unsigned_inputs) begin
                            w_twos_nxt  = w_zext;
                            w_state_nxt = OUT;
                        end else begin
                            w_state_nxt = WAIT_N;
                        end
                    end else begin
                        // n without a pending p: drop it and flag.
                        w_perr_nxt = 1'b1;
                    end
                end
            end

            WAIT_N: begin
                if (w_accept) begin
                    if (in_phase == PHASE_N) begin
                        w_twos_nxt  = w_diff;
                        w_state_nxt = OUT;
                    end else begin
                        // A second p replaces the first; still waiting for n.
                        w_p_nxt    = in_mag;
                        w_perr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = WAIT_P;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= WAIT_P;
            r_p     <= '0;
            r_twos  <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_twos  <= w_twos_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    assign out_twos  = r_twos;
    assign phase_err = r_perr;

endmodule : bipolar_to_twos

// File: tb/tb_bipolar_to_twos.sv
module tb_bipolar_to_twos;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic uns  = 1'b0;
    logic iv   = 1'b0;
    logic ph   = 1'b0;
    logic ordy = 1'b0;

    logic [0:0][3:0] mag1 = '0;
    logic [3:0][3:0] mag4 = '0;

    logic irdy1, ov1, pe1;
    logic signed [0:0][4:0] ot1;
    logic irdy4, ov4, pe4;
    logic signed [3:0][4:0] ot4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bipolar_to_twos #(.magBits(4), .numLanes(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .unsigned_inputs(uns), .in_valid(iv),
        .in_ready(irdy1), .in_phase(ph), .in_mag(mag1), .out_valid(ov1),
        .out_ready(ordy), .out_twos(ot1), .phase_err(pe1)
    );

    bipolar_to_twos #(.magBits(4), .numLanes(4)) u_dut4 (
        .clk(clk), .nrst(nrst), .unsigned_inputs(uns), .in_valid(iv),
        .in_ready(irdy4), .in_phase(ph), .in_mag(mag4), .out_valid(ov4),
        .out_ready(ordy), .out_twos(ot4), .phase_err(pe4)
    );

    typedef struct {
        logic [3:0] p;
        logic [3:0] n;
        int         res;
    } pair_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int s1();
        int v;
        v = $signed(ot1[0]);
        return v;
    endfunction

    function automatic int s4(input int l);
        int v;
        v = $signed(ot4[l]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic p_ph, input logic [3:0] m, input logic u, input logic r);
        iv      = 1'b1;
        ph      = p_ph;
        mag1[0] = m;
        uns     = u;
        ordy    = r;
    endtask

    task automatic idle(input logic r);
        iv   = 1'b0;
        ordy = r;
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        #1;
    endtask

    pair_t tbl[5];
    int    p_l[4];
    int    n_l[4];
    int    e_l[4];

    // reference model state (transaction level)
    bit m_out, m_wn, m_err, exp_rdy, acc;
    int m_res, m_p, m_mag;

    initial begin
        tbl[0] = '{p: 4'd7,  n: 4'd3,  res: 4};
        tbl[1] = '{p: 4'd0,  n: 4'd8,  res: -8};
        tbl[2] = '{p: 4'd15, n: 4'd0,  res: 15};
        tbl[3] = '{p: 4'd15, n: 4'd15, res: 0};
        tbl[4] = '{p: 4'd0,  n: 4'd0,  res: 0};
        p_l = '{1, 0, 7, 4};
        n_l = '{0, 3, 7, 9};
        e_l = '{1, -3, 0, -5};

        // reset state
        #12;
        chk("rst_out_valid", ov1, 0);
        chk("rst_out_twos", s1(), 0);
        chk("rst_phase_err", pe1, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        #1;
        chk("rst_in_ready", irdy1, 1);

        // signed pairs
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, tbl[i].p, 1'b0, 1'b0);
            tick();
            chk("pair_no_out_after_p", ov1, 0);
            beat(1'b1, tbl[i].n, 1'b0, 1'b0);
            #1;
            chk("pair_ready_waitn", irdy1, 1);
            tick();
            chk("pair_valid", ov1, 1);
            chk("pair_value", s1(), tbl[i].res);
            idle(1'b1);
            tick();
            chk("pair_consumed", ov1, 0);
        end

        // unsigned back-to-back
        beat(1'b0, 4'd15, 1'b1, 1'b1);
        tick();
        chk("uns_valid0", ov1, 1);
        chk("uns_val0", s1(), 15);
        beat(1'b0, 4'd1, 1'b1, 1'b1);
        #1;
        chk("uns_ready1", irdy1, 1);
        tick();
        chk("uns_valid1", ov1, 1);
        chk("uns_val1", s1(), 1);
        beat(1'b0, 4'd9, 1'b1, 1'b1);
        #1;
        chk("uns_ready2", irdy1, 1);
        tick();
        chk("uns_valid2", ov1, 1);
        chk("uns_val2", s1(), 9);
        idle(1'b1);
        uns = 1'b0;
        tick();
        chk("uns_drained", ov1, 0);

        // backpressure
        beat(1'b0, 4'd5, 1'b0, 1'b1);
        tick();
        beat(1'b1, 4'd9, 1'b0, 1'b1);
        tick();
        chk("bp_valid", ov1, 1);
        chk("bp_val", s1(), -4);
        beat(1'b0, 4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready_low", irdy1, 0);
            tick();
            chk("bp_hold_valid", ov1, 1);
            chk("bp_hold_val", s1(), -4);
        end
        idle(1'b1);
        tick();
        chk("bp_released", ov1, 0);
        // held beat must not have been taken: a lone n now is out of order
        beat(1'b1, 4'd1, 1'b0, 1'b1);
        tick();
        chk("bp_wait_p_err", pe1, 1);
        chk("bp_wait_p_noout", ov1, 0);
        idle(1'b1);
        tick();
        chk("err_one_cycle", pe1, 0);

        // p, p, n
        beat(1'b0, 4'd2, 1'b0, 1'b1);
        tick();
        chk("pp_first_noerr", pe1, 0);
        beat(1'b0, 4'd6, 1'b0, 1'b1);
        tick();
        chk("pp_second_err", pe1, 1);
        chk("pp_second_noout", ov1, 0);
        beat(1'b1, 4'd1, 1'b0, 1'b1);
        tick();
        chk("ppn_err_clear", pe1, 0);
        chk("ppn_valid", ov1, 1);
        chk("ppn_val", s1(), 5);
        // n while output leaves
        beat(1'b1, 4'd4, 1'b0, 1'b1);
        tick();
        chk("n_in_out_err", pe1, 1);
        chk("n_in_out_noout", ov1, 0);
        idle(1'b1);
        tick();

        // unsigned_inputs toggling mid-pair
        beat(1'b0, 4'd4, 1'b0, 1'b1);
        tick();
        beat(1'b1, 4'd6, 1'b1, 1'b1);
        tick();
        chk("midpair_valid", ov1, 1);
        chk("midpair_val", s1(), -2);
        idle(1'b1);
        uns = 1'b0;
        tick();

        // four-lane instance
        pulse_reset();
        iv = 1'b1; ph = 1'b0; uns = 1'b0; ordy = 1'b1;
        for (int l = 0; l < 4; l++) mag4[l] = 4'(p_l[l]);
        tick();
        ph = 1'b1;
        for (int l = 0; l < 4; l++) mag4[l] = 4'(n_l[l]);
        tick();
        chk("lane4_valid", ov4, 1);
        for (int l = 0; l < 4; l++) chk($sformatf("lane4_val%0d", l), s4(l), e_l[l]);
        idle(1'b1);
        tick();
        iv = 1'b1; ph = 1'b0;
        for (int l = 0; l < 4; l++) mag4[l] = 4'd9;
        tick();
        idle(1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("lane4_rst_valid", ov4, 0);
        chk("lane4_rst_val0", s4(0), 0);
        nrst = 1'b1;
        iv = 1'b1; ph = 1'b1; ordy = 1'b1;
        for (int l = 0; l < 4; l++) mag4[l] = 4'd1;
        tick();
        chk("lane4_lone_n_err", pe4, 1);
        chk("lane4_lone_n_noout", ov4, 0);
        idle(1'b1);
        tick();

        // randomized against the transaction model
        pulse_reset();
        m_out = 0; m_wn = 0; m_err = 0; m_res = 0; m_p = 0;
        for (int c = 0; c < 2000; c++) begin
            iv      = ($urandom_range(0, 3) != 0);
            ph      = $urandom_range(0, 2) == 0;
            uns     = $urandom_range(0, 3) == 0;
            ordy    = $urandom_range(0, 9) < 7;
            mag1[0] = 4'($urandom_range(0, 15));
            m_mag   = int'(mag1[0]);
            #1;
            exp_rdy = !m_out || ordy;
            chk("rnd_in_ready", irdy1, int'(exp_rdy));
            acc = iv && exp_rdy;
            if (m_out && ordy) m_out = 0;
            m_err = 0;
            if (acc) begin
                if (!ph) begin
                    m_p = m_mag;
                    if (m_wn) m_err = 1;
                    else if (uns) begin
                        m_res = m_p;
                        m_out = 1;
                    end else m_wn = 1;
                end else begin
                    if (m_wn) begin
                        m_res = m_p - m_mag;
                        m_out = 1;
                        m_wn  = 0;
                    end else m_err = 1;
                end
            end
            tick();
            chk("rnd_out_valid", ov1, int'(m_out));
            chk("rnd_phase_err", pe1, int'(m_err));
            if (m_out) chk("rnd_out_twos", s1(), m_res);
        end

        idle(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bipolar_to_twos

// File: doc/bipolar_to_twos.md
BIPOLAR_TO_TWOS -- requirements
Module: bipolar_to_twos

Interface
REQ-001 SHALL have parameter magBits, default 4: width of each bipolar magnitude lane.
REQ-002 SHALL have parameter numLanes, default 1: number of parallel lanes.
REQ-003 SHALL have port clk  input  1: single clock, all state rising-edge.
REQ-004 SHALL have port nrst  input  1: asynchronous active-low reset.
REQ-005 SHALL have port unsigned_inputs  input  1: 1 = positive plane only, no negative phase expected.
REQ-006 SHALL have port in_valid  input  1: input beat valid.
REQ-007 SHALL have port in_ready  output  1: block accepts beat this cycle.
REQ-008 SHALL have port in_phase  input  1: 0 = positive plane (p), 1 = negative plane (n).
REQ-009 SHALL have port in_mag  input  [numLanes][magBits]: unsigned magnitude per lane.
REQ-010 SHALL have port out_valid  output  1: result valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts result.
REQ-012 SHALL have port out_twos  output  signed [numLanes][magBits+1]: two's-complement result per lane.
REQ-013 SHALL have port phase_err  output  1: one-cycle pulse on an out-of-order phase beat.

Function
REQ-014 A beat SHALL be accepted iff in_valid && in_ready on a rising edge; an output SHALL be consumed iff out_valid && out_ready.
REQ-015 The FSM SHALL have states WAIT_P, WAIT_N and OUT.
REQ-016 WAIT_P: in_ready=1. An accepted phase-0 beat SHALL store in_mag as p per lane. unsigned_inputs SHALL be sampled at this acceptance.
REQ-017 WAIT_P, after a phase-0 accept: if unsigned_inputs=1, out_twos SHALL load zero-extended p and the FSM SHALL go to OUT; otherwise it SHALL go to WAIT_N.
REQ-018 WAIT_N: in_ready=1. An accepted phase-1 beat SHALL load out_twos = zext(p) - zext(in_mag) per lane and the FSM SHALL go to OUT.
REQ-019 Arithmetic SHALL be magBits+1 bits wide with no saturation (range -(2^magBits-1)..+(2^magBits-1), overflow impossible); p=n SHALL give 0.
REQ-020 OUT: out_valid=1, out_twos held stable until consumed; in_ready = out_ready.
REQ-021 OUT: when the output is consumed with no beat accepted, the FSM SHALL go to WAIT_P.
REQ-022 OUT: when the output is consumed and a phase-0 beat is accepted in the same cycle, the block SHALL behave as in REQ-016/017, so back-to-back unsigned results sustain one result per cycle.
REQ-023 Latency SHALL be one cycle: out_valid rises on the edge after the completing accept.
REQ-024 A phase-1 beat accepted in WAIT_P, or in OUT with out_ready=1, SHALL be dropped with no state change, and phase_err SHALL pulse high for one cycle.
REQ-025 A phase-0 beat accepted in WAIT_N SHALL overwrite p, remain in WAIT_N, and pulse phase_err for one cycle.
REQ-026 out_valid SHALL never be 0 while in OUT, and out_twos SHALL not change while out_valid && !out_ready.
REQ-027 A change of unsigned_inputs mid-pair SHALL not affect the pair in progress.

Reset
REQ-028 When nrst=0 the block SHALL asynchronously enter WAIT_P and set out_valid=0, out_twos=0, phase_err=0 and p=0; in_ready SHALL be 1 after nrst deasserts.
REQ-029 Reset mid-pair or mid-OUT SHALL discard the pending data; no output SHALL appear afterwards without a fresh accept.

Structure
REQ-030 The FSM state enum (WAIT_P, WAIT_N, OUT) and the phase constants PHASE_P=0 and PHASE_N=1 SHALL live in the shared accelerator package.
REQ-031 The per-lane zero-extend-and-subtract SHALL be one combinational sub-module, bipolar_lane_sub, instantiated numLanes times.

Verification (magBits=4, numLanes=1 unless stated)
REQ-032 Signed pair p=7, then n=3 -> out_twos=+4 (5'b00100), out_valid one cycle after the n accept.
REQ-033 Signed pairs (0,8) -> -8 (5'b11000); (15,0) -> +15; (15,15) -> 0; (0,0) -> 0.
REQ-034 Unsigned mode with beats 15, 1, 9 sent back-to-back and out_ready=1 -> outputs +15, +1, +9 on consecutive cycles, in_ready held 1.
REQ-035 Backpressure: out_ready=0 for 5 cycles in OUT -> out_twos stable, in_ready=0, no beat lost; release -> result consumed, FSM returns to WAIT_P.
REQ-036 Phase errors: phase-1 beat in WAIT_P -> phase_err pulse, nothing output; phase-0 beat p=2 then p=6 then n=1 -> phase_err pulse on the second p, result +5.
REQ-037 numLanes=4: lanes p={1,0,7,4}, n={0,3,7,9} -> out_twos={+1,-3,0,-5}; nrst asserted in WAIT_N -> out_valid=0, and the next lone n beat yields phase_err.
